// File: rtl/color_special_effects.sv
// color_special_effects: 3-stage alpha/brighten/darken pipeline on BGR555 pixels, tagged with screen column.
module color_special_effects #(
  parameter int LINE_W = 240,
  parameter int COL_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      color0,
  input  logic [14:0]      color1,
  input  logic [2:0]       top_id,
  input  logic [2:0]       bot_id,
  input  logic             top_semi,
  input  logic             fx_en,
  input  logic [13:0]      bldcnt,
  input  logic [12:0]      bldalpha,
  input  logic [4:0]       bldy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_color,
  output logic [COL_W-1:0] out_col
);
  typedef enum logic [1:0] {NONE, ALPHA, BRIGHT, DARK} fx_t;
  logic             adv, xfer, first, second;
  logic [5:0]       tgt1, tgt2;
  logic [1:0]       mode;
  fx_t              fx, fx1, fx2;
  logic             v1, v2;
  logic [14:0]      a1, b1, a2, res;
  logic [4:0]       eva1, evb1, evy1;
  logic [9:0]       pn [3];
  logic [9:0]       qn [3];
  logic [9:0]       p2 [3];
  logic [9:0]       q2 [3];
  logic [10:0]      sm [3];
  logic [COL_W-1:0] cnt;

  function automatic logic [4:0] clamp(input logic [4:0] v);
    return v > 5'd16 ? 5'd16 : v;
  endfunction

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign xfer     = out_valid & out_ready;
  assign tgt1     = bldcnt[5:0];
  assign tgt2     = bldcnt[13:8];
  assign mode     = bldcnt[7:6];
  assign first    = top_id <= 3'd5 && tgt1[top_id];
  assign second   = bot_id <= 3'd5 && tgt2[bot_id];
  assign out_col  = out_valid ? (line_start ? '0 : cnt) : '0;

  // semi-transparent OBJ forces alpha whenever a second target lies beneath, regardless of mode
  always_comb
    fx = !fx_en ? NONE :
         (top_semi && second) ? ALPHA :
         !first ? NONE :
         mode == 2'd1 ? (second ? ALPHA : NONE) :
         mode == 2'd2 ? BRIGHT :
         mode == 2'd3 ? DARK : NONE;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pn[c] = 10'(fx1 == BRIGHT ? 5'd31 - a1[5*c +: 5] : a1[5*c +: 5]) * 10'(fx1 == ALPHA ? eva1 : evy1);
      qn[c] = 10'(b1[5*c +: 5]) * 10'(evb1);
    end
  end

  // weights are clamped to 16, so brighten/darken shifts never exceed 31 and need no saturation
  always_comb begin
    res = a2;
    for (int c = 0; c < 3; c++) begin
      sm[c] = 11'(p2[c]) + 11'(q2[c]);
      res[5*c +: 5] = fx2 == ALPHA  ? (|sm[c][10:9] ? 5'd31 : sm[c][8:4]) :
                      fx2 == BRIGHT ? a2[5*c +: 5] + p2[c][8:4] :
                      fx2 == DARK   ? a2[5*c +: 5] - p2[c][8:4] : a2[5*c +: 5];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      fx1  <= fx;
      a1   <= color0;
      b1   <= color1;
      eva1 <= clamp(bldalpha[4:0]);
      evb1 <= clamp(bldalpha[12:8]);
      evy1 <= clamp(bldy);
      fx2  <= fx1;
      a2   <= a1;
      p2   <= pn;
      q2   <= qn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_color <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      out_color <= res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (line_start)
      cnt <= COL_W'(xfer);
    else if (xfer)
      cnt <= cnt == COL_W'(LINE_W - 1) ? '0 : cnt + COL_W'(1);
  end
endmodule

// File: tb/tb_color_special_effects.sv
// tb_color_special_effects: directed vectors with a queue scoreboard checked by an output monitor.
module tb_color_special_effects;
  logic        clk = 0, rst_n = 0, line_start = 0, in_valid = 0, out_ready = 1;
  logic        top_semi = 0, fx_en = 0, in_ready, out_valid;
  logic [14:0] color0 = 0, color1 = 0, out_color;
  logic [2:0]  top_id = 0, bot_id = 0;
  logic [13:0] bldcnt = 0;
  logic [12:0] bldalpha = 0;
  logic [4:0]  bldy = 0;
  logic [7:0]  out_col;

  typedef struct packed {logic [14:0] color; logic [7:0] col;} exp_t;
  exp_t        sb[$];
  exp_t        em;
  int          checks = 0, errors = 0, out_count = 0, exp_col = 0, base = 0;
  logic        held_v = 0;
  logic [14:0] held_c = 0;

  color_special_effects #(.LINE_W(240), .COL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .in_valid(in_valid), .in_ready(in_ready),
    .color0(color0), .color1(color1), .top_id(top_id), .bot_id(bot_id), .top_semi(top_semi),
    .fx_en(fx_en), .bldcnt(bldcnt), .bldalpha(bldalpha), .bldy(bldy), .out_valid(out_valid),
    .out_ready(out_ready), .out_color(out_color), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        held_v = 0;
        out_count++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_color), 32'hdead);
        end else begin
          em = sb.pop_front();
          chk($sformatf("color#%0d", out_count), 32'(out_color), 32'(em.color));
          chk($sformatf("col#%0d", out_count), 32'(out_col), 32'(em.col));
        end
      end else if (out_valid) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        if (held_v) chk("stall_hold", 32'(out_color), 32'(held_c));
        held_v = 1;
        held_c = out_color;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] a, input logic [14:0] b, input logic [2:0] t, input logic [2:0] bo,
                      input logic s, input logic f, input logic [13:0] cn, input logic [12:0] al,
                      input logic [4:0] y, input logic [14:0] e);
    int n = 0;
    sb.push_back({e, 8'(exp_col)});
    exp_col = exp_col == 239 ? 0 : exp_col + 1;
    color0 = a; color1 = b; top_id = t; bot_id = bo; top_semi = s; fx_en = f;
    bldcnt = cn; bldalpha = al; bldy = y; in_valid = 1;
    #2;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n == 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    cyc(2);
  endtask

  task automatic pulse_ls();
    line_start = 1;
    cyc(1);
    line_start = 0;
    exp_col = 0;
  endtask

  task automatic wait_count(input int target);
    int n = 0;
    while (out_count != target && n < 100) begin
      cyc(1);
      n++;
    end
    if (n == 100) chk("out_count_timeout", 32'(out_count), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_color", 32'(out_color), 0);
    chk("rst_out_col", 32'(out_col), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1;
    cyc(1);
    // alpha, saturation, zero weights
    send(15'h7FFF, 15'h0000, 0, 1, 0, 1, 14'h0241, 13'h0808, 0, 15'h3DEF);
    send(15'h7FFF, 15'h7FFF, 0, 1, 0, 1, 14'h0241, 13'h1014, 0, 15'h7FFF);
    send(15'h7FFF, 15'h7FFF, 0, 1, 0, 1, 14'h0241, 13'h0000, 0, 15'h0000);
    // brighten, with EVY clamp and back-to-back register change
    send(15'h0000, 15'h0000, 0, 1, 0, 1, 14'h0081, 0, 16, 15'h7FFF);
    send(15'h0000, 15'h0000, 0, 1, 0, 1, 14'h0081, 0, 8, 15'h3DEF);
    send(15'h0000, 15'h0000, 0, 1, 0, 1, 14'h0081, 0, 31, 15'h7FFF);
    // darken
    send(15'h7FFF, 15'h0000, 0, 1, 0, 1, 14'h00C1, 0, 8, 15'h4210);
    send(15'h2A9E, 15'h0000, 0, 1, 0, 1, 14'h00C1, 0, 4, 15'h21F7);
    // gating: window off, top not a target, alpha without 2nd target, top id none
    send(15'h1234, 15'h0000, 0, 1, 0, 0, 14'h00C1, 0, 8, 15'h1234);
    send(15'h1234, 15'h0000, 2, 1, 0, 1, 14'h00C1, 0, 8, 15'h1234);
    send(15'h1234, 15'h7FFF, 0, 5, 0, 1, 14'h0241, 13'h0808, 0, 15'h1234);
    send(15'h1234, 15'h7FFF, 6, 1, 0, 1, 14'h3FFF, 13'h0808, 8, 15'h1234);
    // semi-transparent OBJ over BG2 with mode 0
    send(15'h2A9E, 15'h0886, 4, 2, 1, 1, 14'h0400, 13'h0808, 0, 15'h1992);
    drain();
    // stall mid-stream
    base = out_count;
    fork
      for (int i = 1; i <= 5; i++) send(15'(i), 0, 0, 0, 0, 0, 0, 0, 0, 15'(i));
      begin
        wait_count(base + 2);
        out_ready = 0;
        cyc(4);
        out_ready = 1;
      end
    join
    drain();
    // full line plus wrap
    pulse_ls();
    for (int i = 0; i < 241; i++) send(15'(i * 7), 0, 0, 0, 0, 0, 0, 0, 0, 15'(i * 7));
    drain();
    // line_start coinciding with the third output transfer
    pulse_ls();
    base = out_count;
    fork
      begin
        send(15'h0011, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0011);
        send(15'h0022, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0022);
        exp_col = 0;
        send(15'h0033, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0033);
        send(15'h0044, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0044);
      end
      begin
        wait_count(base + 2);
        line_start = 1;
        cyc(1);
        line_start = 0;
      end
    join
    drain();
    // asynchronous reset discards an in-flight pixel
    out_ready = 0;
    color0 = 15'h5555; fx_en = 0; in_valid = 1;
    cyc(1);
    in_valid = 0;
    cyc(3);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_color", 32'(out_color), 0);
    cyc(1);
    rst_n = 1;
    out_ready = 1;
    exp_col = 0;
    cyc(5);
    send(15'h7FFF, 15'h0000, 0, 1, 0, 1, 14'h0241, 13'h0808, 0, 15'h3DEF);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
